// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter.
// Runs one host request: clock inhibit, start bit, 8 data bits LSB first, odd parity and stop.
// It then checks the device acknowledge bit.
// Both lines are open-drain. The *_oe outputs pull the line low when 1.
module ps2_host_tx #(
  parameter int unsigned ClkFreq       = 50000000,
  parameter int unsigned InhibitCycles = ClkFreq / 10000,
  parameter int unsigned TimeoutCycles = ClkFreq / 500,
  parameter int unsigned FilterLen     = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  input  logic       ps2_clk_in_i,
  input  logic       ps2_data_in_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int unsigned CntMax = (TimeoutCycles > InhibitCycles) ? TimeoutCycles : InhibitCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned FltW   = $clog2(FilterLen + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  // Index 0 is the PS/2 clock line, index 1 is the PS/2 data line.
  logic [1:0]      sync1_q, sync2_q, filt_q;
  logic [FltW-1:0] fcnt_q [2];
  logic            clk_prev_q;
  logic            fall;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      edge_q, edge_d;
  logic [10:0]     frame_q, frame_d;
  logic            timeout;

  // Synchronise both lines, then debounce them with a consecutive-sample filter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
    end else begin
      sync1_q    <= {ps2_data_in_i, ps2_clk_in_i};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FltW'(FilterLen - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FltW'(1);
        end
      end
    end
  end

  assign fall    = clk_prev_q & ~filt_q[0];
  assign timeout = (cnt_q == CntW'(TimeoutCycles));

  // FSM state, shared inhibit/timeout counter, edge counter and latched frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic and line/handshake outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    edge_d        = edge_q;
    frame_d       = frame_q;
    tx_ready_o    = 1'b0;
    tx_done_o     = 1'b0;
    tx_error_o    = 1'b0;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          // Frame bit 0 is the start bit; bit 10 is the stop bit.
          frame_d = {1'b1, ~^tx_data_i, tx_data_i, 1'b0};
          cnt_d   = '0;
          edge_d  = '0;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        ps2_clk_oe_o = 1'b1;
        if (cnt_q == CntW'(InhibitCycles - 1)) begin
          // The counter is reused as the timeout counter from REQ onwards.
          cnt_d   = '0;
          state_d = StReq;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReq: begin
        ps2_clk_oe_o  = 1'b1;
        ps2_data_oe_o = 1'b1;
        state_d       = StSend;
      end
      StSend: begin
        ps2_data_oe_o = ~frame_q[edge_q];
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (!filt_q[1]) begin
            state_d = StWaitIdle;
          end else begin
            tx_error_o = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (filt_q[0] && filt_q[1]) begin
          tx_done_o = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // The timeout overrides whatever the active state decided, including edge 11.
    if (state_q inside {StReq, StSend, StAck, StWaitIdle}) begin
      cnt_d = cnt_q + CntW'(1);
      if (timeout) begin
        ps2_clk_oe_o  = 1'b0;
        ps2_data_oe_o = 1'b0;
        tx_done_o     = 1'b0;
        tx_error_o    = 1'b1;
        state_d       = StIdle;
      end
    end

    // Nothing is reported while reset is held.
    if (!rst_ni) begin
      tx_ready_o = 1'b0;
      tx_done_o  = 1'b0;
      tx_error_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 device model clocking at 12.5 kHz.
module tb_ps2_host_tx;

  localparam int unsigned ClkFreq = 1000000;
  localparam int unsigned FiltLen = 4;
  localparam int          Inhibit = 100;
  localparam int          Timeout = 2000;
  localparam int          Half    = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error, clk_oe, data_oe;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  wire clk_line  = ~(clk_oe | dev_clk_low);
  wire data_line = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .ClkFreq  (ClkFreq),
    .FilterLen(FiltLen)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_done_o    (tx_done),
    .tx_error_o   (tx_error),
    .ps2_clk_in_i (clk_line),
    .ps2_data_in_i(data_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, req_cyc = 0;
  int inh_run = 0, last_inh = 0, inh_cnt = 0;
  int both_viol = 0, ready_viol = 0;
  logic prev_pulse = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor of the handshake and line outputs, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (clk_oe && data_oe) req_cyc <= cyc;
    if (tx_done && tx_error) both_viol <= both_viol + 1;
    if (((tx_done || tx_error) && tx_ready) || (tx_ready && (clk_oe || data_oe)) ||
        (prev_pulse && !tx_ready && rst_n))
      ready_viol <= ready_viol + 1;
    if (clk_oe && !data_oe) begin
      inh_run <= inh_run + 1;
    end else begin
      if (inh_run != 0) begin
        last_inh <= inh_run;
        inh_cnt  <= inh_cnt + 1;
      end
      inh_run <= 0;
    end
    prev_pulse <= tx_done | tx_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept ready", 32'(tx_ready), 32'd0);
    check("accept clk_oe", 32'(clk_oe), 32'd1);
  endtask

  // Device side: start bit sampled at request, bits 1..10 sampled on rising clock edges,
  // acknowledge driven with falling edge 11.
  task automatic dev_xfer(input bit ack_ok, input int glitch_bit, input int abort_bit,
                          output logic [10:0] bits, output bit ok);
    int n;
    ok   = 1'b0;
    bits = '0;
    n    = 0;
    while (!(clk_line && !data_line) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) return;
    repeat (10) @(negedge clk);
    bits[0] = data_line;
    for (int k = 1; k <= 11; k++) begin
      if (k == glitch_bit) begin
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (Half - 13) @(negedge clk);
      end else begin
        repeat (Half) @(negedge clk);
      end
      if (k == 11) dev_data_low = ack_ok;
      dev_clk_low = 1'b1;
      if (k == abort_bit) begin
        repeat (10) @(negedge clk);
        ok = 1'b1;
        return;
      end
      repeat (Half) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = data_line;
    end
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_end(input int d0, input int e0, input int limit, output bit ok);
    int n;
    n = 0;
    #1;
    while (done_cnt == d0 && err_cnt == e0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (done_cnt != d0) || (err_cnt != e0);
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack_ok, input int glitch_bit,
                      input logic [10:0] exp_bits, input string tag);
    int d0, e0, i0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    i0 = inh_cnt;
    send(b);
    // A second request during the transfer must be dropped.
    @(negedge clk);
    tx_data  = ~b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_xfer(ack_ok, glitch_bit, 0, bits, ok);
    check({tag, " dev"}, 32'(ok), 32'd1);
    check({tag, " bits"}, 32'(bits), 32'(exp_bits));
    wait_end(d0, e0, 600, ok);
    check({tag, " end"}, 32'(ok), 32'd1);
    check({tag, " done"}, done_cnt - d0, ack_ok ? 32'd1 : 32'd0);
    check({tag, " error"}, err_cnt - e0, ack_ok ? 32'd0 : 32'd1);
    check({tag, " inhibits"}, inh_cnt - i0, 32'd1);
    check({tag, " inhibit len"}, last_inh, 32'(Inhibit));
    @(negedge clk);
    check({tag, " ready after"}, 32'(tx_ready), 32'd1);
    check({tag, " oe after"}, {30'd0, clk_oe, data_oe}, 32'd0);
  endtask

  initial begin
    int d0, e0, i0;
    logic [10:0] bits;
    bit ok;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(tx_ready), 32'd0);
    check("reset oe", {30'd0, clk_oe, data_oe}, 32'd0);
    check("reset pulses", {30'd0, tx_done, tx_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", 32'(tx_ready), 32'd1);

    // 0xED: frame {stop, parity, data, start} = {1, 1, 8'hED, 0}.
    xfer(8'hED, 1'b1, 0, 11'h7DA, "ed");

    i0 = inh_cnt;
    xfer(8'h00, 1'b1, 0, 11'h600, "b2b 00");
    xfer(8'hFF, 1'b1, 0, 11'h7FE, "b2b ff");
    xfer(8'h01, 1'b1, 0, 11'h402, "b2b 01");
    check("b2b frames", inh_cnt - i0, 32'd3);

    xfer(8'h3C, 1'b0, 0, 11'h678, "nack");

    // Silent device: error lands exactly Timeout cycles after REQ.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h77);
    wait_end(d0, e0, 2600, ok);
    check("tmo end", 32'(ok), 32'd1);
    check("tmo error", err_cnt - e0, 32'd1);
    check("tmo done", done_cnt - d0, 32'd0);
    check("tmo latency", err_cyc - req_cyc, 32'(Timeout));
    @(negedge clk);
    check("tmo ready", 32'(tx_ready), 32'd1);
    check("tmo oe", {30'd0, clk_oe, data_oe}, 32'd0);

    xfer(8'hA5, 1'b1, 3, 11'h74A, "glitch");

    // Reset while bit 5 is on the wire.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hC3);
    dev_xfer(1'b1, 0, 5, bits, ok);
    check("rst dev", 32'(ok), 32'd1);
    check("rst bits", 32'(bits[4:0]), 32'h06);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst oe", {30'd0, clk_oe, data_oe}, 32'd0);
    check("rst ready", 32'(tx_ready), 32'd0);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    check("rst pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    xfer(8'h5A, 1'b1, 0, 11'h6B4, "after rst");

    check("done+error overlap", both_viol, 32'd0);
    check("ready protocol", ready_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
